clock_ctrl: RTL

CLOCK_CTRL -- requirements
Module: clock_ctrl

---
 rtl/clock_pkg.sv | 29 ++
 rtl/clock_ctrl_if.sv | 33 +++
 rtl/clock_ctrl_edge_det.sv | 29 ++
 rtl/clock_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock controller: edit-mode state encoding, field-select
// encodings and time-field widths.
package clock_pkg;

  localparam int unsigned HourW = 5;
  localparam int unsigned MinW  = 6;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } state_e;

  localparam logic [1:0] SelNone    = 2'b00;
  localparam logic [1:0] SelHours   = 2'b01;
  localparam logic [1:0] SelMinutes = 2'b10;

  // Field-select code shown while in a given state.
  function automatic logic [1:0] sel_of(state_e s);
    logic [1:0] sel;
    unique case (s)
      SET_HH:  sel = SelHours;
      SET_MM:  sel = SelMinutes;
      default: sel = SelNone;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/clock_ctrl_if.sv
// Signal bundle between the clock controller and its environment.
//   tick      : 1 Hz one-cycle pulse from the divider
//   btn_mode  : mode button level (synchronized, debounced)
//   btn_inc   : increment button level (synchronized, debounced)
//   hours/minutes/seconds : current time, binary
//   sel       : field being edited (00 none, 01 hours, 10 minutes)
//   div_clr   : one-cycle pulse restarting the divider
//   day_pulse : one-cycle pulse on midnight rollover
// master = the environment driving buttons/tick, slave = the controller.
interface clock_ctrl_if;
  import clock_pkg::*;

  logic             tick;
  logic             btn_mode;
  logic             btn_inc;
  logic [HourW-1:0] hours;
  logic [MinW-1:0]  minutes;
  logic [MinW-1:0]  seconds;
  logic [1:0]       sel;
  logic             div_clr;
  logic             day_pulse;

  modport master (
    output tick, btn_mode, btn_inc,
    input  hours, minutes, seconds, sel, div_clr, day_pulse
  );

  modport slave (
    input  tick, btn_mode, btn_inc,
    output hours, minutes, seconds, sel, div_clr, day_pulse
  );

endinterface

// File: rtl/clock_ctrl_edge_det.sv
// 1-bit rising-edge detector.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   d    : level input
//   rise : high in the cycle where d is 1 and its registered previous value was 0
// RstVal sets the reset value of the previous-value register; resetting it to 1 keeps a
// level held through reset release from being seen as an edge.
module edge_det #(
  parameter bit RstVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q <= RstVal;
    end else begin
      prev_q <= d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Time-of-day clock controller with a two-field set mode.
//   clk : clock, all state changes on rising edge
//   rst : asynchronous active-low reset
//   bus : clock_ctrl_if.slave (tick/buttons in; time, sel, div_clr, day_pulse out)
// Mode button cycles RUN -> SET_HH -> SET_MM -> RUN. Entering SET_HH zeroes the seconds;
// leaving SET_MM restarts the divider so the first second after setting is full length.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned HOUR_MAX = 23,
  parameter int unsigned MIN_MAX  = 59
) (
  input logic         clk,
  input logic         rst,
  clock_ctrl_if.slave bus
);

  localparam logic [HourW-1:0] HourMax = HourW'(HOUR_MAX);
  localparam logic [MinW-1:0]  MinMax  = MinW'(MIN_MAX);

  state_e           state_q, state_d;
  logic [HourW-1:0] hours_q, hours_d;
  logic [MinW-1:0]  min_q, min_d;
  logic [MinW-1:0]  sec_q, sec_d;
  logic [1:0]       sel_q, sel_d;
  logic             div_clr_q, div_clr_d;
  logic             day_pulse_q, day_pulse_d;

  logic mode_rise;
  logic inc_rise;

  edge_det #(
    .RstVal (1'b1)
  ) u_mode_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.btn_mode),
    .rise (mode_rise)
  );

  edge_det #(
    .RstVal (1'b1)
  ) u_inc_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.btn_inc),
    .rise (inc_rise)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (mode_rise) begin
      unique case (state_q)
        RUN:     state_d = SET_HH;
        SET_HH:  state_d = SET_MM;
        SET_MM:  state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Time fields and registered outputs.
  always_comb begin
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    sec_wrap    = (sec_q == MinMax);
    min_wrap    = (min_q == MinMax);
    hour_wrap   = (hours_q == HourMax);

    hours_d     = hours_q;
    min_d       = min_q;
    sec_d       = sec_q;
    div_clr_d   = 1'b0;
    day_pulse_d = 1'b0;
    sel_d       = sel_of(state_d);

    unique case (state_q)
      RUN: begin
        if (bus.tick) begin
          sec_d = sec_wrap ? '0 : sec_q + 1'b1;
          if (sec_wrap) begin
            min_d = min_wrap ? '0 : min_q + 1'b1;
            if (min_wrap) begin
              hours_d = hour_wrap ? '0 : hours_q + 1'b1;
            end
          end
          day_pulse_d = sec_wrap & min_wrap & hour_wrap;
        end
        // Entering set mode zeroes seconds after any carry from a coincident tick.
        if (mode_rise) begin
          sec_d = '0;
        end
      end
      SET_HH: begin
        // A mode edge takes priority over an increment edge in the same cycle.
        if (!mode_rise && inc_rise) begin
          hours_d = hour_wrap ? '0 : hours_q + 1'b1;
        end
      end
      SET_MM: begin
        if (mode_rise) begin
          div_clr_d = 1'b1;
        end else if (inc_rise) begin
          min_d = min_wrap ? '0 : min_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours_q     <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      sel_q       <= SelNone;
      div_clr_q   <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      hours_q     <= hours_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      sel_q       <= sel_d;
      div_clr_q   <= div_clr_d;
      day_pulse_q <= day_pulse_d;
    end
  end

  assign bus.hours     = hours_q;
  assign bus.minutes   = min_q;
  assign bus.seconds   = sec_q;
  assign bus.sel       = sel_q;
  assign bus.div_clr   = div_clr_q;
  assign bus.day_pulse = day_pulse_q;

endmodule
